// File: rtl/dd_puf_eval_ctrl.sv
// Evaluation sequencer for the dual-latch delay-difference PUF array: runs NUM_EVAL
// reset/start/hold cycles, majority-votes each response bit and hands the result downstream.
module dd_puf_eval_ctrl #(
  parameter int WIDTH         = 128,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_EVAL      = 15,
  parameter int CNT_W         = $clog2(NUM_EVAL + 1),
  parameter int UC_W          = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ,
  input  logic [WIDTH-1:0] PUF_RESP,
  output logic             PUF_RESET,
  output logic             PUF_START,
  output logic             BUSY,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [WIDTH-1:0] RESP_DATA,
  output logic [WIDTH-1:0] STABLE_MASK,
  output logic [UC_W-1:0]  UNSTABLE_COUNT
);

  localparam int HOLD_CYCLES = 3;
  localparam int RS_MAX      = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PH_MAX      = (RS_MAX > HOLD_CYCLES) ? RS_MAX : HOLD_CYCLES;
  localparam int PH_W        = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int EV_W        = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_HOLD, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [EV_W-1:0]        eval_q, eval_d;
  logic [CNT_W-1:0]       ones_q [WIDTH];
  logic [CNT_W-1:0]       ones_d [WIDTH];
  logic [WIDTH-1:0]       sync1_q, sync2_q;
  logic [WIDTH-1:0]       resp_q, resp_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [UC_W-1:0]        ucnt_q, ucnt_d;
  logic                   phase_last, eval_last, accept, sample, finish;

  function automatic logic majority(input logic [CNT_W-1:0] cnt);
    return cnt > CNT_W'(NUM_EVAL / 2);
  endfunction

  function automatic logic unanimous(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) || (cnt == CNT_W'(NUM_EVAL));
  endfunction

  function automatic logic [UC_W-1:0] count_unstable(input logic [WIDTH-1:0] m);
    logic [UC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + UC_W'(!m[i]);
    return c;
  endfunction

  always_comb begin
    phase_last = 1'b0;
    case (state_q)
      S_CLEAR: phase_last = (phase_q == PH_W'(RESET_CYCLES - 1));
      S_RUN:   phase_last = (phase_q == PH_W'(SETTLE_CYCLES - 1));
      S_HOLD:  phase_last = (phase_q == PH_W'(HOLD_CYCLES - 1));
      default: phase_last = 1'b0;
    endcase
    eval_last = (eval_q == EV_W'(NUM_EVAL - 1));
    accept    = (state_q == S_IDLE) && REQ;
    sample    = (state_q == S_HOLD) && phase_last;
    finish    = sample && eval_last;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (REQ)        state_d = S_CLEAR;
      S_CLEAR: if (phase_last) state_d = S_RUN;
      S_RUN:   if (phase_last) state_d = S_HOLD;
      S_HOLD:  if (phase_last) state_d = eval_last ? S_DONE : S_CLEAR;
      S_DONE:  if (RESP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Cells stay parked in clear whenever no evaluation phase is running.
  always_comb begin
    PUF_RESET  = (state_q == S_IDLE) || (state_q == S_CLEAR) || (state_q == S_DONE);
    PUF_START  = (state_q == S_RUN);
    BUSY       = (state_q != S_IDLE);
    RESP_VALID = (state_q == S_DONE);
  end

  always_comb begin
    phase_d = '0;
    if (((state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_HOLD)) && !phase_last)
      phase_d = phase_q + PH_W'(1);

    eval_d = eval_q;
    if (accept)                   eval_d = '0;
    else if (sample && !eval_last) eval_d = eval_q + EV_W'(1);

    for (int i = 0; i < WIDTH; i++) begin
      ones_d[i] = ones_q[i];
      if (accept)      ones_d[i] = '0;
      else if (sample) ones_d[i] = ones_q[i] + CNT_W'(sync2_q[i]);
    end

    // The vote uses ones_d so the final evaluation's sample is included.
    resp_d = resp_q;
    mask_d = mask_q;
    if (finish) begin
      for (int i = 0; i < WIDTH; i++) begin
        resp_d[i] = majority(ones_d[i]);
        mask_d[i] = unanimous(ones_d[i]);
      end
    end
    ucnt_d = finish ? count_unstable(mask_d) : ucnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q <= '0;
      eval_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      resp_q  <= '0;
      mask_q  <= '0;
      ucnt_q  <= '0;
      for (int i = 0; i < WIDTH; i++) ones_q[i] <= '0;
    end else begin
      phase_q <= phase_d;
      eval_q  <= eval_d;
      sync1_q <= PUF_RESP;
      sync2_q <= sync1_q;
      resp_q  <= resp_d;
      mask_q  <= mask_d;
      ucnt_q  <= ucnt_d;
      for (int i = 0; i < WIDTH; i++) ones_q[i] <= ones_d[i];
    end
  end

  assign RESP_DATA      = resp_q;
  assign STABLE_MASK    = mask_q;
  assign UNSTABLE_COUNT = ucnt_q;

endmodule
